// File: rtl/counter_ascii_pkg.sv
// counter_ascii_pkg: shared types and constants for the counter ASCII transmit path.
// Optional build macro: COUNTER_ASCII_CRLF_EN (appends CR/LF after the digit bytes).
package counter_ascii_pkg;

  // Formatter sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Largest count the 10000-counter can produce; anything above is clamped
  localparam int DEFAULT_MAX_VALUE = 9999;

  // Number of line-terminator bytes appended after the digits
`ifdef COUNTER_ASCII_CRLF_EN
  localparam int TERM_BYTES = 2;
`else
  localparam int TERM_BYTES = 0;
`endif

  // Map a BCD digit (0..9) to its ASCII character
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return ASCII_ZERO + {4'h0, digit};
  endfunction

endpackage

// File: rtl/counter_ascii_tx_bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift per clock.
// A conversion takes exactly VAL_W cycles after the start cycle; o_done pulses
// for one cycle when the result is ready and o_bcd then holds until the next start.
module bin2bcd_seq #(
  parameter int VAL_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [VAL_W-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);

  logic [VAL_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic             done_reg;

  // Add-3 correction on every digit that would overflow past 9 after the shift
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                  ? bcd_reg[gi*4 +: 4] + 4'd3
                                  : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // Load on start, then shift one binary bit into the BCD register per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (i_start && !busy_reg) begin
        bin_reg  <= i_bin;
        bcd_reg  <= '0;
        cnt_reg  <= '0;
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        bcd_reg <= {bcd_adj[BCD_W-2:0], bin_reg[VAL_W-1]};
        bin_reg <= {bin_reg[VAL_W-2:0], 1'b0};
        if (cnt_reg == CNT_W'(VAL_W - 1)) begin
          cnt_reg  <= '0;
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign o_busy = busy_reg;
  assign o_done = done_reg;
  assign o_bcd  = bcd_reg;

endmodule

// File: rtl/counter_ascii_tx.sv
// counter_ascii_tx: formats a binary count as fixed-width decimal ASCII and
// pushes it byte by byte into the UART TX FIFO, most significant digit first.
// Optional build macro: COUNTER_ASCII_CRLF_EN appends CR, LF after the digits.
module counter_ascii_tx
  import counter_ascii_pkg::*;
#(
  parameter int VAL_W     = 14,
  parameter int DIGITS    = 4,
  parameter int MAX_VALUE = DEFAULT_MAX_VALUE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [VAL_W-1:0] i_value,
  input  logic             i_tx_full,
  output logic             o_push,
  output logic [7:0]       o_push_data,
  output logic             o_busy,
  output logic             o_done
);

  // Digits plus optional terminator bytes emitted per request
  localparam int NUM_BYTES = DIGITS + TERM_BYTES;
  localparam int IDX_W     = $clog2(NUM_BYTES + 1);

  state_t               state_reg;
  state_t               state_next;
  logic [IDX_W-1:0]     idx_reg;
  logic [VAL_W-1:0]     sat_value;
  logic                 bcd_start;
  logic                 bcd_busy;
  logic                 bcd_done;
  logic [4*DIGITS-1:0]  bcd_value;
  logic                 push_ok;
  logic                 last_byte;

  // Clamp before conversion so every BCD digit is guaranteed to be 0..9
  assign sat_value = (i_value > VAL_W'(MAX_VALUE)) ? VAL_W'(MAX_VALUE) : i_value;

  // A start is only accepted from IDLE; the converter latches the clamped value
  assign bcd_start = (state_reg == IDLE) && i_start;

  // A byte leaves only when sending and the FIFO has room
  assign push_ok   = (state_reg == SEND) && !i_tx_full;
  assign last_byte = (idx_reg == IDX_W'(NUM_BYTES - 1));

  bin2bcd_seq #(
    .VAL_W  (VAL_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst     (rst),
    .i_start (bcd_start),
    .i_bin   (sat_value),
    .o_busy  (bcd_busy),
    .o_done  (bcd_done),
    .o_bcd   (bcd_value)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          state_next = CONVERT;
        end
      end
      CONVERT: begin
        if (bcd_done && !bcd_busy) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (push_ok && last_byte) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte index: advances only on an actual push, cleared outside SEND
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg <= '0;
    end else if (state_reg != SEND) begin
      idx_reg <= '0;
    end else if (push_ok) begin
      idx_reg <= last_byte ? '0 : idx_reg + 1'b1;
    end
  end

  // Outputs: push strobe, byte select by index, busy/done flags
  always_comb begin
    o_push      = 1'b0;
    o_push_data = 8'h00;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (state_reg)
      CONVERT: begin
        o_busy = 1'b1;
      end
      SEND: begin
        o_busy = 1'b1;
        o_push = !i_tx_full;
        // Digit DIGITS-1 (most significant) goes out at index 0
        for (int d = 0; d < DIGITS; d++) begin
          if (idx_reg == IDX_W'(DIGITS - 1 - d)) begin
            o_push_data = digit_to_ascii(bcd_value[d*4 +: 4]);
          end
        end
`ifdef COUNTER_ASCII_CRLF_EN
        if (idx_reg == IDX_W'(DIGITS)) begin
          o_push_data = ASCII_CR;
        end
        if (idx_reg == IDX_W'(DIGITS + 1)) begin
          o_push_data = ASCII_LF;
        end
`endif
      end
      DONE: begin
        o_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_counter_ascii_tx.sv
// Self-checking bench for counter_ascii_tx: table vectors, hand-written
// reset/stall/restart sequences and randomized values against a decimal model.
module tb_counter_ascii_tx;

`ifdef COUNTER_ASCII_CRLF_EN
  localparam int NB = 6;
`else
  localparam int NB = 4;
`endif
  localparam int FIRST_K = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [13:0] i_value;
  logic        i_tx_full;
  logic        o_push;
  logic [7:0]  o_push_data;
  logic        o_busy;
  logic        o_done;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [13:0] val;
    int          mode;   // 0 plain, 1 stall at index 1, 3 restart in CONVERT, 4 start in DONE
    logic [31:0] ascii;  // expected digit bytes, MSD in the top byte
  } vec_t;

  vec_t tbl[7];

  counter_ascii_tx dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_value     (i_value),
    .i_tx_full   (i_tx_full),
    .o_push      (o_push),
    .o_push_data (o_push_data),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Reference: clamp, then split into decimal digits with plain arithmetic
  function automatic void model_expected(input int val);
    int v;
    v = (val > 9999) ? 9999 : val;
    exp_q.delete();
    exp_q.push_back(8'(8'h30 + (v / 1000)));
    exp_q.push_back(8'(8'h30 + (v / 100) % 10));
    exp_q.push_back(8'(8'h30 + (v / 10) % 10));
    exp_q.push_back(8'(8'h30 + v % 10));
    if (NB == 6) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  function automatic void table_expected(input logic [31:0] asc);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(asc[31-8*i -: 8]);
    if (NB == 6) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  // One request; k counts cycles sampled after the edge that accepts the start
  task automatic run_txn(input logic [13:0] val, input int mode, input string tag);
    logic [7:0] got[$];
    int first_k = -1, last_k = -1, done_k = -1, done_cnt = 0;
    int busy_err = 0, stall_err = 0, extra_err = 0, full_err = 0, post = 0, stall_left = 5;
    @(posedge clk); #1;
    i_start = 1'b1; i_value = val; i_tx_full = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      #1;
      i_start = 1'b0; i_tx_full = 1'b0;
      if (mode == 3 && k == 3) begin i_start = 1'b1; i_value = 14'd1111; end
      if (mode == 4 && k == FIRST_K + NB) begin i_start = 1'b1; i_value = 14'd1111; end
      if (mode == 1 && got.size() == 1 && stall_left > 0) begin i_tx_full = 1'b1; stall_left--; end
      if (mode == 2) i_tx_full = ($urandom_range(0, 2) == 0);
      #1;
      if (mode == 1 && i_tx_full && (o_push !== 1'b0 || o_push_data !== exp_q[1])) stall_err++;
      if (i_tx_full && o_push) full_err++;
      if (o_push === 1'b1) begin
        if (got.size() == 0) first_k = k;
        last_k = k;
        got.push_back(o_push_data);
      end
      if (done_k < 0) begin
        if (o_done === 1'b1) begin
          done_k = k; done_cnt++;
          if (o_busy !== 1'b0) busy_err++;
        end else if (o_busy !== 1'b1) busy_err++;
      end else begin
        post++;
        if (o_done === 1'b1) done_cnt++;
        if (o_push !== 1'b0 || o_busy !== 1'b0) extra_err++;
      end
      if (done_k >= 0 && post >= 20) break;
      @(posedge clk);
    end
    i_start = 1'b0; i_tx_full = 1'b0;
    check({tag, "/done_seen"}, 32'(done_k >= 0), 32'd1);
    check({tag, "/byte_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s/byte%0d", tag, i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
    check({tag, "/done_pulses"}, done_cnt, 32'd1);
    check({tag, "/done_after_last"}, done_k, last_k + 1);
    check({tag, "/busy_flag"}, busy_err, 0);
    check({tag, "/quiet_after"}, extra_err, 0);
    check({tag, "/push_while_full"}, full_err, 0);
    if (mode == 0 || mode == 3 || mode == 4) check({tag, "/first_push_k"}, first_k, FIRST_K);
    if (mode == 1) begin
      check({tag, "/stall_hold"}, stall_err, 0);
      check({tag, "/stall_last_k"}, last_k, FIRST_K + NB - 1 + 5);
    end
    $display("txn %s value=%0d mode=%0d bytes=%0d first_k=%0d done_k=%0d", tag, val, mode, got.size(), first_k, done_k);
  endtask

  initial begin
    int pushes, quiet_err;
    rst = 1'b1; i_start = 1'b0; i_value = '0; i_tx_full = 1'b0;

    tbl[0] = '{14'd1234,  0, 32'h31323334};
    tbl[1] = '{14'd0,     0, 32'h30303030};
    tbl[2] = '{14'd7,     0, 32'h30303037};
    tbl[3] = '{14'd12000, 0, 32'h39393939};
    tbl[4] = '{14'd5678,  1, 32'h35363738};
    tbl[5] = '{14'd4321,  3, 32'h34333231};
    tbl[6] = '{14'd9999,  4, 32'h39393939};

    repeat (3) @(posedge clk);
    #1;
    check("reset/o_push", o_push, 0);
    check("reset/o_push_data", o_push_data, 0);
    check("reset/o_busy", o_busy, 0);
    check("reset/o_done", o_done, 0);
    rst = 1'b0;

    for (int t = 0; t < 7; t++) begin
      table_expected(tbl[t].ascii);
      run_txn(tbl[t].val, tbl[t].mode, $sformatf("vec%0d", t));
    end

    // Reset in the middle of sending 9876, right after the second byte
    model_expected(9876);
    @(posedge clk); #1;
    i_start = 1'b1; i_value = 14'd9876;
    @(posedge clk); #1;
    i_start = 1'b0;
    pushes = 0;
    for (int k = 0; k < 100 && pushes < 2; k++) begin
      #1;
      if (o_push === 1'b1) pushes++;
      @(posedge clk); #1;
    end
    check("rstmid/two_pushes_seen", pushes, 2);
    rst = 1'b1;
    #1;
    check("rstmid/o_push", o_push, 0);
    check("rstmid/o_push_data", o_push_data, 0);
    check("rstmid/o_busy", o_busy, 0);
    check("rstmid/o_done", o_done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    quiet_err = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #2;
      if (o_push !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0) quiet_err++;
    end
    check("rstmid/quiet_after_reset", quiet_err, 0);
    $display("txn rstmid value=9876 aborted after %0d bytes", pushes);
    model_expected(42);
    run_txn(14'd42, 0, "after_rst");

    // Randomized values, with and without random FIFO back-pressure
    for (int r = 0; r < 20; r++) begin
      logic [13:0] v;
      v = 14'($urandom_range(0, 16383));
      model_expected(int'(v));
      run_txn(v, (r % 2 == 0) ? 0 : 2, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
